// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2R/1W integer register file
// with a per-register pending-write scoreboard for hazard stalls.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              iClk,
   input  logic              iRstN,
   input  logic              iWriteEn,
   input  logic [ADDR_W-1:0] iRdAddr,
   input  logic [DATA_W-1:0] iWriteData,
   input  logic [ADDR_W-1:0] iRs1Addr,
   input  logic [ADDR_W-1:0] iRs2Addr,
   output logic [DATA_W-1:0] oRs1Data,
   output logic [DATA_W-1:0] oRs2Data,
   input  logic              iIssueEn,
   input  logic [ADDR_W-1:0] iIssueRd,
   input  logic              iFlush,
   output logic              oRs1Busy,
   output logic              oRs2Busy,
   output logic              oRdBusy,
   output logic [ADDR_W:0]   oPendingCnt
);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] pend;
   logic [NUM_REGS-1:0] pend_nxt;
   logic [ADDR_W:0]     cnt_nxt;
   logic                wr_ok;
   logic                iss_ok;

   // x0 is never stored to or marked pending when hardwired
   always_comb begin
      wr_ok  = iWriteEn;
      iss_ok = iIssueEn;
      if (ZERO_REG != 0 && iRdAddr == '0)
         wr_ok = 1'b0;
      if (ZERO_REG != 0 && iIssueRd == '0)
         iss_ok = 1'b0;
   end

   // register array write port
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (wr_ok) begin
         regs[iRdAddr] <= iWriteData;
      end
   end

   // scoreboard next state: flush, then clear on write, set on issue wins
   always_comb begin
      pend_nxt = pend;
      if (iFlush) begin
         pend_nxt = '0;
      end else begin
         if (iWriteEn)
            pend_nxt[iRdAddr] = 1'b0;
         if (iss_ok)
            pend_nxt[iIssueRd] = 1'b1;
      end
   end

   // population count of the next scoreboard
   always_comb begin
      cnt_nxt = '0;
      for (int i = 0; i < NUM_REGS; i++)
         cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[i]};
   end

   // scoreboard and count registers
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         pend        <= '0;
         oPendingCnt <= '0;
      end else begin
         pend        <= pend_nxt;
         oPendingCnt <= cnt_nxt;
      end
   end

   // read ports: zero register, then same-cycle bypass, then array
   always_comb begin
      oRs1Data = regs[iRs1Addr];
      oRs2Data = regs[iRs2Addr];
      if (BYPASS != 0 && iWriteEn && iRdAddr == iRs1Addr)
         oRs1Data = iWriteData;
      if (BYPASS != 0 && iWriteEn && iRdAddr == iRs2Addr)
         oRs2Data = iWriteData;
      if (ZERO_REG != 0 && iRs1Addr == '0)
         oRs1Data = '0;
      if (ZERO_REG != 0 && iRs2Addr == '0)
         oRs2Data = '0;
   end

   // busy flags with the same zero and bypass masking as the data
   always_comb begin
      oRs1Busy = pend[iRs1Addr];
      oRs2Busy = pend[iRs2Addr];
      oRdBusy  = pend[iIssueRd];
      if (BYPASS != 0 && iWriteEn && iRdAddr == iRs1Addr)
         oRs1Busy = 1'b0;
      if (BYPASS != 0 && iWriteEn && iRdAddr == iRs2Addr)
         oRs2Busy = 1'b0;
      if (BYPASS != 0 && iWriteEn && iRdAddr == iIssueRd)
         oRdBusy = 1'b0;
      if (ZERO_REG != 0 && iRs1Addr == '0)
         oRs1Busy = 1'b0;
      if (ZERO_REG != 0 && iRs2Addr == '0)
         oRs2Busy = 1'b0;
      if (ZERO_REG != 0 && iIssueRd == '0)
         oRdBusy = 1'b0;
   end

endmodule
